// File: rtl/dma_block_writer.sv
// dma_block_writer
// Captures a block of BLOCK_SIZE signed words on a start request and streams
// them, one word per accepted cycle, to consecutive memory addresses starting
// at a captured base address. mem_wait stalls the current write. A one-cycle
// done pulse follows the final accepted word. Every output is registered.
module dma_block_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 25
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] blk_data,
    input  logic                             mem_wait,
    output logic                             enable,
    output logic                             RW,
    output logic [ADDR_WIDTH-1:0]            address,
    output logic [DATA_WIDTH-1:0]            inputDATA,
    output logic                             busy,
    output logic                             done
);

    // Index wide enough to count 0..BLOCK_SIZE-1 (at least one bit).
    localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    // Transfer bookkeeping
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_inc;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic                   capture;

    // Registered memory-side and status outputs
    logic                   enable_q, enable_d;
    logic                   rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Unpacked view of the incoming block and the captured copy of it
    logic [DATA_WIDTH-1:0]  blk_words [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0]  buf_q     [BLOCK_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_unpack
            assign blk_words[gi] = blk_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign idx_inc = idx_q + IDX_W'(1);

    // Block buffer: loaded in one shot when a start is accepted, otherwise
    // frozen so that blk_data changes mid-transfer have no effect.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                buf_q[i] <= blk_words[i];
            end
        end
    end

    // FSM state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: the last word leaves WRITE only once accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!mem_wait && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: computes the next value of every registered output.
    // Address and data hold by default; the bus is only driven in WRITE.
    always_comb begin
        capture  = 1'b0;
        idx_d    = idx_q;
        base_d   = base_q;
        enable_d = 1'b0;
        rw_d     = 1'b1;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Word 0 goes straight from the inputs to the bus so it
                    // appears in the cycle right after the start edge.
                    capture  = 1'b1;
                    base_d   = base_addr;
                    idx_d    = '0;
                    enable_d = 1'b1;
                    rw_d     = 1'b0;
                    addr_d   = base_addr;
                    data_d   = blk_words[0];
                    busy_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                enable_d = 1'b1;
                rw_d     = 1'b0;
                busy_d   = 1'b1;
                if (!mem_wait) begin
                    if (idx_q == LAST_IDX) begin
                        enable_d = 1'b0;
                        rw_d     = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        // Address wraps naturally at 2^ADDR_WIDTH.
                        idx_d  = idx_inc;
                        addr_d = base_q + ADDR_WIDTH'(idx_inc);
                        data_d = buf_q[idx_inc];
                    end
                end
            end
            ST_DONE: begin
                idx_d = '0;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything at once so an
    // in-flight transfer is abandoned without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            base_q   <= '0;
            enable_q <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            base_q   <= base_d;
            enable_q <= enable_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign enable    = enable_q;
    assign RW        = rw_q;
    assign address   = addr_q;
    assign inputDATA = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dma_block_writer.sv
// Self-checking bench for dma_block_writer: a transaction-level model of the
// block transfer is compared against the DUT outputs on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_dma_block_writer;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BS = 25;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              start     = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [BS*DW-1:0]  blk_data  = '0;
    logic              mem_wait  = 1'b0;
    logic              enable;
    logic              RW;
    logic [AW-1:0]     address;
    logic [DW-1:0]     inputDATA;
    logic              busy;
    logic              done;

    dma_block_writer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .blk_data  (blk_data),
        .mem_wait  (mem_wait),
        .enable    (enable),
        .RW        (RW),
        .address   (address),
        .inputDATA (inputDATA),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural model: a transfer is "active" with a word pointer, or in
    // its one-cycle "done" phase, or idle. Bus values hold while not active.
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    int            m_k      = 0;
    logic [AW-1:0] m_base   = '0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_data   = '0;
    logic [DW-1:0] m_words [BS];

    logic [AW+DW-1:0] exp_log [$];
    logic [AW+DW-1:0] dut_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: check, log accepted writes, then advance the model by
    // the edge that follows (inputs only change just after rising edges).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            m_addr   = '0;
            m_data   = '0;
        end
        check("enable", 32'(enable),    32'(m_active));
        check("RW",     32'(RW),        32'(!m_active));
        check("busy",   32'(busy),      32'(m_active));
        check("done",   32'(done),      32'(m_done));
        check("address",32'(address),   32'(m_addr));
        check("data",   32'(inputDATA), 32'(m_data));
        if (rst_n) begin
            if (enable && !RW && !mem_wait) dut_log.push_back({address, inputDATA});
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_active) begin
                if (!mem_wait) begin
                    exp_log.push_back({m_addr, m_data});
                    m_k++;
                    if (m_k == BS) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end else begin
                        m_addr = m_base + AW'(m_k);
                        m_data = m_words[m_k];
                    end
                end
            end else if (start) begin
                for (int k = 0; k < BS; k++) m_words[k] = blk_data[k*DW +: DW];
                m_base   = base_addr;
                m_k      = 0;
                m_active = 1'b1;
                m_addr   = base_addr;
                m_data   = m_words[0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic fill_random();
        for (int k = 0; k < BS; k++) blk_data[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic fill_count();
        for (int k = 0; k < BS; k++) blk_data[k*DW +: DW] = DW'(k + 1);
    endtask

    // Bounded wait for the done pulse, then check its latency from start.
    task automatic wait_done(input int exp_lat, input string name);
        int guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check({name, "_done"},    32'(done), 32'd1);
        check({name, "_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
        $display("txn %s: done after %0d cycles", name, cyc - start_cyc);
    endtask

    logic [DW-1:0]    orig [BS];
    logic [AW+DW-1:0] e;

    initial begin
        // Reset values, asserted asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_enable",  32'(enable),    32'd0);
        check("rst_RW",      32'(RW),        32'd1);
        check("rst_address", 32'(address),   32'd0);
        check("rst_data",    32'(inputDATA), 32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_done",    32'(done),      32'd0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();

        // Nominal block: word k = k+1 at 0x0100+k
        fill_count();
        dut_log.delete();
        pulse_start(16'h0100);
        for (int k = 0; k < BS; k++) begin
            check("nom_addr", 32'(address),   32'(16'h0100 + k));
            check("nom_data", 32'(inputDATA), 32'(k + 1));
            check("nom_RW",   32'(RW),        32'd0);
            tick();
        end
        check("nom_done",   32'(done),   32'd1);
        check("nom_enable", 32'(enable), 32'd0);
        check("nom_busy",   32'(busy),   32'd0);
        tick();
        check("nom_done_one_cycle", 32'(done), 32'd0);
        check("nom_count", 32'(dut_log.size()), 32'd25);
        for (int k = 0; k < BS && k < dut_log.size(); k++) begin
            e = {AW'(32'h0100 + k), DW'(k + 1)};
            check("nom_write", dut_log[k], e);
        end
        $display("txn nominal: %0d writes logged", dut_log.size());

        // Stall of 3 cycles while word 5 is on the bus
        pulse_start(16'h0200);
        for (int k = 0; k < 5; k++) tick();
        check("stall_w5_addr", 32'(address), 32'h0205);
        mem_wait = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            check("stall_hold_addr", 32'(address),   32'h0205);
            check("stall_hold_data", 32'(inputDATA), 32'd6);
            check("stall_hold_en",   32'(enable),    32'd1);
        end
        mem_wait = 1'b0;
        tick();
        check("stall_next_addr", 32'(address),   32'h0206);
        check("stall_next_data", 32'(inputDATA), 32'd7);
        wait_done(28, "stall");
        tick();

        // Address wrap
        fill_random();
        pulse_start(16'hFFF0);
        for (int k = 0; k < 15; k++) tick();
        check("wrap_top", 32'(address), 32'hFFFF);
        tick();
        check("wrap_zero", 32'(address), 32'h0000);
        wait_done(25, "wrap");
        tick();

        // Signed extremes pass through unchanged
        fill_random();
        blk_data[0*DW +: DW] = 16'h8000;
        blk_data[1*DW +: DW] = 16'hFFFF;
        pulse_start(16'h0400);
        check("signed_8000", 32'(inputDATA), 32'h8000);
        tick();
        check("signed_ffff", 32'(inputDATA), 32'hFFFF);
        wait_done(25, "signed");
        tick();

        // Re-pulsed start and changing blk_data mid-transfer are ignored
        fill_random();
        for (int k = 0; k < BS; k++) orig[k] = blk_data[k*DW +: DW];
        dut_log.delete();
        pulse_start(16'h0500);
        tick(); tick(); tick();
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fill_random();
            tick();
        end
        start = 1'b0;
        wait_done(25, "ignore");
        start = 1'b1;
        tick();
        check("start_in_done_en",   32'(enable), 32'd0);
        check("start_in_done_busy", 32'(busy),   32'd0);
        start = 1'b0;
        tick();
        check("after_done_idle", 32'(enable), 32'd0);
        check("ignore_count", 32'(dut_log.size()), 32'd25);
        for (int k = 0; k < BS && k < dut_log.size(); k++) begin
            e = {AW'(32'h0500 + k), orig[k]};
            check("ignore_write", dut_log[k], e);
        end
        $display("txn ignore: %0d writes logged", dut_log.size());

        // Randomised traffic: random starts, data, bases and stalls
        for (int c = 0; c < 400; c++) begin
            start     = ($urandom_range(0, 5) == 0);
            base_addr = AW'($urandom);
            fill_random();
            mem_wait  = ($urandom_range(0, 2) == 0);
            tick();
        end
        start    = 1'b0;
        mem_wait = 1'b0;
        for (int c = 0; c < 60; c++) tick();
        $display("txn random: %0d model writes so far", exp_log.size());

        // Asynchronous reset between edges while word 10 is on the bus
        fill_random();
        pulse_start(16'h0300);
        for (int k = 0; k < 10; k++) tick();
        check("pre_rst_addr", 32'(address), 32'h030A);
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(enable),  32'd0);
        check("arst_busy",   32'(busy),    32'd0);
        check("arst_addr",   32'(address), 32'd0);
        check("arst_done",   32'(done),    32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_en",   32'(enable), 32'd0);
            check("post_rst_done", 32'(done),   32'd0);
        end
        fill_random();
        pulse_start(16'h0000);
        check("fresh_addr", 32'(address), 32'h0000);
        wait_done(25, "fresh");
        tick();

        // Start honoured at the first edge after reset release
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fill_random();
        pulse_start(16'h0600);
        check("first_start_en",   32'(enable),  32'd1);
        check("first_start_addr", 32'(address), 32'h0600);
        wait_done(25, "first_start");
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t expected under 200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_block_writer.md
DMA_BLOCK_WRITER -- requirements
Module: dma_block_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed word width.
REQ-003 SHALL have parameter BLOCK_SIZE, default 25, words per block.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to write one block; sampled on posedge.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  memory address of word 0.
REQ-008 SHALL have port blk_data  input  BLOCK_SIZE*DATA_WIDTH  flattened block; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port mem_wait  input  1  memory stall; 1 = hold the current write.
REQ-010 SHALL have port enable  output  1  memory enable.
REQ-011 SHALL have port RW  output  1  memory direction; 1 = read, 0 = write.
REQ-012 SHALL have port address  output  ADDR_WIDTH  memory write address.
REQ-013 SHALL have port inputDATA  output  DATA_WIDTH  memory write data.
REQ-014 SHALL have port busy  output  1  high while a block transfer is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final word is written.

Function
REQ-016 SHALL implement an FSM with states IDLE, WRITE and DONE.
REQ-017 SHALL register all outputs; no output depends combinationally on any input.
REQ-018 IDLE with start=1 at edge N: SHALL capture blk_data into an internal BLOCK_SIZE-word buffer and base_addr into a base register, clear index to 0, and enter WRITE.
REQ-019 SHALL keep RW=0 whenever enable=1; no read is ever issued.
REQ-020 In WRITE, each cycle SHALL present enable=1, address=base+index and inputDATA=buffer[index].
REQ-021 SHALL increment index at each edge where mem_wait=0; with mem_wait=1, index, address and inputDATA SHALL hold and enable SHALL stay 1.
REQ-022 Without stalls, word k SHALL be on the bus in cycle N+1+k, so the last word appears in cycle N+BLOCK_SIZE.
REQ-023 When index=BLOCK_SIZE-1 is accepted (mem_wait=0), SHALL enter DONE; enable SHALL be 0 in the following cycle.
REQ-024 DONE SHALL last exactly one cycle: done=1 and busy=0, then return to IDLE.
REQ-025 busy SHALL be 1 in every cycle the FSM is in WRITE.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; base 0xFFF0 wraps to 0x0000 after 0xFFFF.
REQ-027 SHALL ignore start in WRITE and DONE; the buffer SHALL NOT change during a transfer even if blk_data changes.
REQ-028 In IDLE and DONE, enable SHALL be 0, RW SHALL be 1, and address and inputDATA SHALL hold their last values.
REQ-029 A new start SHALL be accepted only in IDLE; the minimum start-to-start spacing is BLOCK_SIZE+2 cycles.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, index 0, enable=0, RW=1, address=0, inputDATA=0, busy=0, done=0.
REQ-031 Reset during WRITE SHALL abort the transfer; after release no further writes occur and no done pulse is issued until a new start.
REQ-032 The first start SHALL be honoured at the first posedge after rst_n rises.

Verification
REQ-033 Nominal: base_addr=0x0100, word k = k+1, start pulse at cycle N, mem_wait=0 -> writes (0x0100+k, k+1) for k=0..24 in cycles N+1..N+25; done=1 at N+26; RW=0 throughout.
REQ-034 Stall: mem_wait=1 for 3 cycles while word 5 is presented -> address 0x0105 and its data held 4 cycles; done is delayed by exactly 3 cycles; no word is skipped or repeated.
REQ-035 Wrap: base_addr=0xFFF0 -> addresses 0xFFF0..0xFFFF, then 0x0000..0x0008.
REQ-036 Ignored start and data change: start re-pulsed and blk_data changed mid-transfer -> the 25 original words are written once; the second start has no effect.
REQ-037 Async reset: rst_n low between clock edges at word 10 -> enable=0 and busy=0 immediately; no done pulse; a later start with base 0x0000 writes a full fresh block.
REQ-038 Signed data: word values 0x8000 and 0xFFFF -> appear unchanged on inputDATA.
